seg7_capture: RTL and testbench

Reads a multiplexed, active-low 4-digit 7-segment display bus and recovers the 16-bit hex value being shown. It inverts the hex-to-segment encoding used by the display drivers. It sits on the verification and loopback side of the counter designs, watching the same `an`/`seg` lines that drive the board display. It publishes a value, with a `valid` pulse, once all four digits have been captured.

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_capture.sv | 161 ++++++++++++++++
 tb/tb_seg7_capture.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the active-low 7-segment display bus and the capture FSM.
package seg7_pkg;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_NONE   = 4'hF;

  typedef enum logic {SETTLE = 1'b0, HELD = 1'b1} state_t;

  function automatic logic an_one_hot(input logic [3:0] an);
    logic [3:0] sel;
    sel = ~an;
    return (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'hE:    idx = 2'd0;
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the display driver table: segment pattern -> nibble, with a
// flag for patterns the driver never produces.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] nib
);

  // Pattern lookup; anything outside the table is reported as not ok
  always_comb begin
    ok  = 1'b1;
    nib = 4'h0;
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: begin
        ok  = 1'b0;
        nib = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Watches a multiplexed active-low 4-digit 7-segment bus and publishes the
// 16-bit value once every digit has been seen, sampling each stable dwell once.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        valid,
  output logic        err
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [3:0]    an_s1_r, an_s2_r, an_prev_r;
  logic [6:0]    seg_s1_r, seg_s2_r, seg_prev_r;
  logic [CW-1:0] cnt_r;
  state_t        state_r, state_nxt_s;
  logic          changed_s, sample_s, ok_s;
  logic [3:0]    nib_s, dig_bit_s;
  logic [1:0]    dig_s;
  logic [3:0]    mask_r, mask_nxt_s;
  logic [15:0]   shadow_r, shadow_nxt_s, value_r, value_nxt_s;
  logic          valid_r, valid_nxt_s, err_r, err_nxt_s;

  // Two-flop synchronizer plus previous-cycle copy for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_r    <= AN_NONE;
      an_s2_r    <= AN_NONE;
      an_prev_r  <= AN_NONE;
      seg_s1_r   <= SEG_BLANK;
      seg_s2_r   <= SEG_BLANK;
      seg_prev_r <= SEG_BLANK;
    end else begin
      an_s1_r    <= an;
      an_s2_r    <= an_s1_r;
      an_prev_r  <= an_s2_r;
      seg_s1_r   <= seg;
      seg_s2_r   <= seg_s1_r;
      seg_prev_r <= seg_s2_r;
    end
  end

  assign changed_s = (an_s2_r != an_prev_r) || (seg_s2_r != seg_prev_r);

  // Stability counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (changed_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SETTLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // One sample per dwell: fire in SETTLE, then wait in HELD for the next change
  always_comb begin
    state_nxt_s = state_r;
    sample_s    = 1'b0;
    case (state_r)
      SETTLE: begin
        if (changed_s) begin
          state_nxt_s = SETTLE;
        end else if (cnt_r == CNT_FIRE) begin
          sample_s    = 1'b1;
          state_nxt_s = HELD;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      HELD: begin
        if (changed_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = HELD;
        end
      end
      default: state_nxt_s = SETTLE;
    endcase
  end

  seg7_decode u_decode (
    .seg (seg_s2_r),
    .ok  (ok_s),
    .nib (nib_s)
  );

  assign dig_s = an_index(an_s2_r);

  // Sample outcome: ignore blank, error on bad pattern/multi-hot, restart on repeat
  always_comb begin
    mask_nxt_s   = mask_r;
    shadow_nxt_s = shadow_r;
    value_nxt_s  = value_r;
    valid_nxt_s  = 1'b0;
    err_nxt_s    = 1'b0;
    dig_bit_s    = 4'b0001 << dig_s;
    if (!sample_s) begin
      mask_nxt_s = mask_r;
    end else if (an_s2_r == AN_NONE) begin
      mask_nxt_s = mask_r;
    end else if (!an_one_hot(an_s2_r) || !ok_s) begin
      err_nxt_s  = 1'b1;
      mask_nxt_s = 4'h0;
    end else if ((mask_r & dig_bit_s) != 4'h0) begin
      mask_nxt_s                          = dig_bit_s;
      shadow_nxt_s[{dig_s, 2'b00} +: 4] = nib_s;
    end else begin
      shadow_nxt_s[{dig_s, 2'b00} +: 4] = nib_s;
      if ((mask_r | dig_bit_s) == 4'hF) begin
        value_nxt_s = shadow_nxt_s;
        valid_nxt_s = 1'b1;
        mask_nxt_s  = 4'h0;
      end else begin
        mask_nxt_s = mask_r | dig_bit_s;
      end
    end
  end

  // Mask, shadow and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r   <= 4'h0;
      shadow_r <= 16'h0000;
      value_r  <= 16'h0000;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      mask_r   <= mask_nxt_s;
      shadow_r <= shadow_nxt_s;
      value_r  <= value_nxt_s;
      valid_r  <= valid_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign value = value_r;
  assign valid = valid_r;
  assign err   = err_r;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: table of digit dwells with expected pulse
// counts and value, plus hand sequences for latency and mid-frame reset.
module tb_seg7_capture;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          dwell;
    int          blank;
    int          exp_valid;
    int          exp_err;
    logic [15:0] exp_value;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        valid;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .an    (an),
    .seg   (seg),
    .value (value),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] a, input logic [6:0] s, input int d, input int b,
                     input int v, input int e, input logic [15:0] val);
    vq.push_back('{a, s, d, b, v, e, val});
  endtask

  // Hold {a,s} for dwell cycles then blank, counting pulses seen at negedges
  task automatic run_step(input logic [3:0] a, input logic [6:0] s, input int dwell,
                          input int blank, output int nv, output int ne, output int nb);
    nv = 0; ne = 0; nb = 0;
    an = a; seg = s;
    for (int c = 0; c < dwell + blank; c++) begin
      if (c == dwell) begin
        an = 4'hF; seg = 7'h7F;
      end
      @(negedge clk);
      if (valid === 1'b1) nv++;
      if (err === 1'b1) ne++;
      if (valid === 1'b1 && err === 1'b1) nb++;
    end
  endtask

  initial begin
    int nv, ne, nb, first, after;

    // scan 1234
    add(4'hE, 7'h19, 10, 2, 0, 0, 16'h0000);
    add(4'hD, 7'h30, 10, 2, 0, 0, 16'h0000);
    add(4'hB, 7'h24, 10, 2, 0, 0, 16'h0000);
    add(4'h7, 7'h79, 10, 2, 1, 0, 16'h1234);
    // bad pattern on digit 2; leftover digit 3 restarted by the clean 5678 scan
    add(4'hE, 7'h19, 10, 2, 0, 0, 16'h1234);
    add(4'hD, 7'h30, 10, 2, 0, 0, 16'h1234);
    add(4'hB, 7'h7E, 10, 2, 0, 1, 16'h1234);
    add(4'h7, 7'h79, 10, 2, 0, 0, 16'h1234);
    add(4'h7, 7'h12, 10, 2, 0, 0, 16'h1234);
    add(4'hE, 7'h00, 10, 2, 0, 0, 16'h1234);
    add(4'hD, 7'h78, 10, 2, 0, 0, 16'h1234);
    add(4'hB, 7'h02, 10, 2, 1, 0, 16'h5678);
    // short dwell ignored, then real digit 3; long invalid dwell -> one err
    add(4'hE, 7'h10, 10, 2, 0, 0, 16'h5678);
    add(4'hD, 7'h06, 10, 2, 0, 0, 16'h5678);
    add(4'hB, 7'h0E, 10, 2, 0, 0, 16'h5678);
    add(4'h7, 7'h40,  3, 2, 0, 0, 16'h5678);
    add(4'h7, 7'h40, 10, 2, 1, 0, 16'h0FE9);
    add(4'hE, 7'h7E, 40, 2, 0, 1, 16'h0FE9);
    // multi-hot an clears mask; full scan ABCD ending on digit 0
    add(4'hE, 7'h19, 10, 2, 0, 0, 16'h0FE9);
    add(4'hC, 7'h40, 10, 2, 0, 1, 16'h0FE9);
    add(4'hD, 7'h46, 10, 2, 0, 0, 16'h0FE9);
    add(4'hB, 7'h03, 10, 2, 0, 0, 16'h0FE9);
    add(4'h7, 7'h08, 10, 2, 0, 0, 16'h0FE9);
    add(4'hE, 7'h21, 10, 2, 1, 0, 16'hABCD);
    // repeated digit 0 restarts the frame
    add(4'hE, 7'h79, 10, 2, 0, 0, 16'hABCD);
    add(4'hD, 7'h24, 10, 2, 0, 0, 16'hABCD);
    add(4'hE, 7'h30, 10, 2, 0, 0, 16'hABCD);
    add(4'hD, 7'h19, 10, 2, 0, 0, 16'hABCD);
    add(4'hB, 7'h12, 10, 2, 0, 0, 16'hABCD);
    add(4'h7, 7'h02, 10, 2, 1, 0, 16'h6543);

    rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_value", value, 16'h0000);
    check("reset_valid", valid, 1'b0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;
    run_step(4'hF, 7'h7F, 10, 0, nv, ne, nb);
    check("idle_pulses", nv + ne, 0);

    foreach (vq[i]) begin
      run_step(vq[i].an, vq[i].seg, vq[i].dwell, vq[i].blank, nv, ne, nb);
      check($sformatf("v%0d_valid", i), nv, vq[i].exp_valid);
      check($sformatf("v%0d_err", i), ne, vq[i].exp_err);
      check($sformatf("v%0d_both", i), nb, 0);
      check($sformatf("v%0d_value", i), value, vq[i].exp_value);
    end

    // latency: valid first seen 7 negedges after the last digit is applied
    run_step(4'hE, 7'h06, 10, 2, nv, ne, nb);
    run_step(4'hD, 7'h0E, 10, 2, nv, ne, nb);
    run_step(4'hB, 7'h08, 10, 2, nv, ne, nb);
    check("lat_pre_valid", nv, 0);
    first = 0; after = 0;
    an = 4'h7; seg = 7'h46;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == first + 1 && first != 0 && valid === 1'b1) after = 1;
      if (valid === 1'b1 && first == 0) first = c;
    end
    an = 4'hF; seg = 7'h7F;
    check("lat_edges", first, 7);
    check("lat_width", after, 0);
    check("lat_value", value, 16'hCAFE);
    run_step(4'hF, 7'h7F, 0, 4, nv, ne, nb);

    // reset mid-frame discards the partial frame
    run_step(4'hE, 7'h78, 10, 2, nv, ne, nb);
    run_step(4'hD, 7'h00, 10, 2, nv, ne, nb);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_value", value, 16'h0000);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_value2", value, 16'h0000);
    rst_n = 1'b1;
    run_step(4'hB, 7'h10, 10, 2, nv, ne, nb);
    check("post_rst_d2_valid", nv, 0);
    run_step(4'h7, 7'h08, 10, 2, nv, ne, nb);
    check("post_rst_d3_valid", nv, 0);
    check("post_rst_err", ne, 0);
    check("post_rst_value", value, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
